// File: rtl/acc_register_pkg.sv
// Shared definitions for the accumulating result register: opcodes and
// elaboration-time helpers.
package acc_register_pkg;

  localparam int OP_W = 3;

  // Codes 6 and 7 are reserved and decode as NOP.
  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_ADD  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5
  } op_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/acc_register_if.sv
// Command and result handshake bundle between the partial-product logic,
// the accumulator and the product consumer.
interface acc_register_if
  import acc_register_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_last, out_ready,
    output cmd_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_last, out_ready,
    input  cmd_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/acc_register_reg_fifo.sv
// Small flop-based in-order FIFO holding {ovf, result} words. Pointers carry
// one extra bit so full and empty are told apart by the pointer difference.
module reg_fifo
  import acc_register_pkg::*;
#(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         sclr_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = (AW > 0) ? AW : 1;

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]             count;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
  logic [IW-1:0]             wr_idx, rd_idx;
  logic                      do_push, do_pop;

  generate
    if (AW == 0) begin : g_single
      assign wr_idx = '0;
      assign rd_idx = '0;
    end else begin : g_multi
      assign wr_idx = wr_ptr_q[IW-1:0];
      assign rd_idx = rd_ptr_q[IW-1:0];
    end
  endgenerate

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_idx];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_idx] = din;
      wr_ptr_d      = wr_ptr_q + PW'(1);
    end
    if (do_pop)
      rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge sclr_n) begin
    if (sclr_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/acc_register.sv
// Accumulating result register: executes one command per handshake on a
// WIDTH-bit accumulator with sticky overflow and queues `last` results.
module acc_register
  import acc_register_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             clk_ena,
  acc_register_if.slave    bus,
  output logic [WIDTH-1:0] acc_q
);
  logic [WIDTH-1:0] acc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   head;
  logic             cmd_fire, push, pop, full, empty;

  // Full blocks every command, regardless of a pop in the same cycle.
  assign bus.cmd_ready = clk_ena && !sclr_n && !full;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign push          = cmd_fire && bus.cmd_last;
  assign bus.out_valid = clk_ena && !empty;
  assign pop           = bus.out_valid && bus.out_ready;
  assign sum           = {1'b0, acc_q} + {1'b0, bus.cmd_data};

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (cmd_fire) begin
      case (bus.cmd_op)
        OP_CLR: begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        OP_LOAD: begin
          acc_d = bus.cmd_data;
          ovf_d = 1'b0;
        end
        OP_ADD: begin
          acc_d = sum[WIDTH-1:0];
          ovf_d = ovf_q | sum[WIDTH];
        end
        OP_SHL: begin
          acc_d = {acc_q[WIDTH-2:0], 1'b0};
          ovf_d = ovf_q | acc_q[WIDTH-1];
        end
        OP_SHR: acc_d = {1'b0, acc_q[WIDTH-1:1]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge sclr_n) begin
    if (sclr_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // The pushed word is the post-op state, so it comes from the next-state terms.
  reg_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .sclr_n (sclr_n),
    .push   (push),
    .din    ({ovf_d, acc_d}),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );

  assign bus.out_data = bus.out_valid ? head[WIDTH-1:0] : '0;
  assign bus.out_ovf  = bus.out_valid ? head[WIDTH]     : 1'b0;

endmodule

// File: tb/tb_acc_register.sv
// Directed bench for acc_register: opcode vector table plus hand-written
// backpressure, clock-enable and asynchronous reset sequences.
module tb_acc_register;

  logic        clk;
  logic        sclr_n;
  logic        clk_ena;
  logic [15:0] acc_q;
  int          checks;
  int          errors;

  acc_register_if #(.WIDTH(16)) bus ();

  acc_register #(.WIDTH(16), .DEPTH(2)) dut (
    .clk     (clk),
    .sclr_n  (sclr_n),
    .clk_ena (clk_ena),
    .bus     (bus),
    .acc_q   (acc_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic        last;
    logic [15:0] acc;
    logic        vld;
    logic [15:0] odata;
    logic        ovf;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] d, input logic l);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_last  = l;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vt[0]  = '{3'd2, 16'h1234, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0};
    vt[1]  = '{3'd2, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vt[2]  = '{3'd3, 16'h0001, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[3]  = '{3'd1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vt[4]  = '{3'd2, 16'h8001, 1'b0, 16'h8001, 1'b0, 16'h0000, 1'b0};
    vt[5]  = '{3'd4, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0002, 1'b1};
    vt[6]  = '{3'd2, 16'h8001, 1'b0, 16'h8001, 1'b0, 16'h0000, 1'b0};
    vt[7]  = '{3'd5, 16'h0000, 1'b1, 16'h4000, 1'b1, 16'h4000, 1'b0};
    vt[8]  = '{3'd3, 16'h4000, 1'b0, 16'h8000, 1'b0, 16'h0000, 1'b0};
    vt[9]  = '{3'd3, 16'h8000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[10] = '{3'd0, 16'h5555, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[11] = '{3'd6, 16'h1234, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[12] = '{3'd5, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[13] = '{3'd2, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 16'h00FF, 1'b0};
    vt[14] = '{3'd4, 16'h0000, 1'b0, 16'h01FE, 1'b0, 16'h0000, 1'b0};
    vt[15] = '{3'd3, 16'h0F02, 1'b1, 16'h1100, 1'b1, 16'h1100, 1'b0};

    // Reset state
    sclr_n  = 1'b0;
    clk_ena = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    #1 sclr_n = 1'b1;
    #1;
    chk("rst_acc", 32'(acc_q), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'h0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    step();
    sclr_n = 1'b0;
    #1;
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'h1);

    // Opcode table, consumer always ready
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vt[i].op, vt[i].data, vt[i].last);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.cmd_ready), 32'h1);
      step();
      chk($sformatf("v%0d_acc", i), 32'(acc_q), 32'(vt[i].acc));
      chk($sformatf("v%0d_vld", i), 32'(bus.out_valid), 32'(vt[i].vld));
      if (vt[i].vld) begin
        chk($sformatf("v%0d_data", i), 32'(bus.out_data), 32'(vt[i].odata));
        chk($sformatf("v%0d_ovf", i), 32'(bus.out_ovf), 32'(vt[i].ovf));
      end
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    step();
    chk("drain_vld", 32'(bus.out_valid), 32'h0);

    // Backpressure: full FIFO blocks the third command
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd2, 16'h0001, 1'b1);
    step();
    chk("bp1_ready", 32'(bus.cmd_ready), 32'h1);
    chk("bp1_data", 32'(bus.out_data), 32'h1);
    drive(1'b1, 3'd2, 16'h0002, 1'b1);
    step();
    chk("bp2_ready", 32'(bus.cmd_ready), 32'h0);
    chk("bp2_acc", 32'(acc_q), 32'h2);
    drive(1'b1, 3'd2, 16'h0003, 1'b1);
    step();
    chk("bp3_ready", 32'(bus.cmd_ready), 32'h0);
    chk("bp3_acc", 32'(acc_q), 32'h2);
    chk("bp3_hold", 32'(bus.out_data), 32'h1);
    bus.out_ready = 1'b1;
    step();
    chk("bp4_data", 32'(bus.out_data), 32'h2);
    chk("bp4_ready", 32'(bus.cmd_ready), 32'h1);
    chk("bp4_acc", 32'(acc_q), 32'h2);
    step();
    chk("bp5_data", 32'(bus.out_data), 32'h3);
    chk("bp5_acc", 32'(acc_q), 32'h3);
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    step();
    chk("bp6_vld", 32'(bus.out_valid), 32'h0);

    // Clock enable low freezes everything
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd2, 16'h00AB, 1'b1);
    step();
    chk("ce_pre_data", 32'(bus.out_data), 32'hAB);
    drive(1'b1, 3'd2, 16'h5555, 1'b1);
    clk_ena = 1'b0;
    #1;
    chk("ce_ready", 32'(bus.cmd_ready), 32'h0);
    chk("ce_vld", 32'(bus.out_valid), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("ce%0d_acc", c), 32'(acc_q), 32'hAB);
      chk($sformatf("ce%0d_vld", c), 32'(bus.out_valid), 32'h0);
      chk($sformatf("ce%0d_ready", c), 32'(bus.cmd_ready), 32'h0);
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    clk_ena = 1'b1;
    #1;
    chk("ce_rest_vld", 32'(bus.out_valid), 32'h1);
    chk("ce_rest_data", 32'(bus.out_data), 32'hAB);
    chk("ce_rest_ovf", 32'(bus.out_ovf), 32'h0);
    step();
    chk("ce_held_data", 32'(bus.out_data), 32'hAB);

    // Asynchronous reset mid-cycle with a pending entry
    #2 sclr_n = 1'b1;
    #1;
    chk("ar_vld", 32'(bus.out_valid), 32'h0);
    chk("ar_acc", 32'(acc_q), 32'h0);
    chk("ar_data", 32'(bus.out_data), 32'h0);
    chk("ar_ready", 32'(bus.cmd_ready), 32'h0);
    step();
    sclr_n = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("ar_stale%0d", c), 32'(bus.out_valid), 32'h0);
    end
    drive(1'b1, 3'd2, 16'h0042, 1'b1);
    step();
    chk("ar_post_data", 32'(bus.out_data), 32'h42);
    chk("ar_post_vld", 32'(bus.out_valid), 32'h1);
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_register.md
# acc_register

Parametrised accumulating result register for the multiplier datapath. It is the successor of the plain 16-bit enable/clear register. It executes one command per accepted handshake (clear, load, add, shift) on a WIDTH-bit accumulator and tracks a sticky overflow flag. On commands marked `last`, it pushes the result into a DEPTH-entry output FIFO with valid/ready backpressure. It sits between the shift-add partial-product logic and the product consumer.

## Interface
- WIDTH, 16, accumulator/data width in bits (≥ 2)
- DEPTH, 2, output FIFO entries (power of 2, ≥ 1)
- clk  in  1  clock; all state changes on rising edge
- sclr_n  in  1  reset, asynchronous, active-high
- clk_ena  in  1  global enable; low freezes all state
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  opcode
- cmd_data  in  WIDTH  operand for LOAD/ADD
- cmd_last  in  1  push post-op accumulator and ovf to FIFO
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops when out_valid && out_ready
- out_data  out  WIDTH  FIFO head result
- out_ovf  out  1  overflow flag captured with out_data
- acc_q  out  WIDTH  live accumulator value (debug/observe)

## Operation
- Opcodes:
  - NOP=0: acc unchanged.
  - CLR=1: acc←0, ovf←0.
  - LOAD=2: acc←cmd_data, ovf←0.
  - ADD=3: acc←(acc+cmd_data) mod 2^WIDTH; ovf←ovf | carry-out.
  - SHL=4: acc←acc<<1, zero-fill; ovf←ovf | acc[WIDTH-1].
  - SHR=5: acc←acc>>1, logical; ovf unchanged.
  - Codes 6 and 7 are reserved and execute as NOP.
- All arithmetic is unsigned. The carry is computed at WIDTH+1 bits.
- A `last` command pushes {post-op acc, post-op ovf}; acc and ovf are not cleared by the push.
- cmd_ready = clk_ena && !sclr_n && !fifo_full. It does not depend on out_ready: a full FIFO blocks all commands, including non-`last` ones, even when a pop occurs in the same cycle.
- out_valid = clk_ena && !fifo_empty. While clk_ena is low, no pops occur.
- FIFO is strict in-order. Pointer width is log2(DEPTH)+1 so full and empty are distinguishable. Wrap-around is modulo DEPTH.
- Simultaneous push and pop (FIFO not full): both occur and the count is unchanged. When empty, a push and a pop cannot coincide; the new entry appears the next cycle.
- clk_ena low: acc, ovf, FIFO contents and pointers are held. The handshake outputs are forced low.

## Timing
- Reset (sclr_n high, asynchronous): acc_q=0, ovf=0, FIFO empty, out_valid=0, out_data=0, out_ovf=0, cmd_ready=0. cmd_ready rises combinationally once sclr_n deasserts (with clk_ena=1).
- Reset mid-operation discards all FIFO entries and the accumulator immediately. No partial result survives.
- Accumulator latency: a command accepted in cycle N is visible on acc_q in cycle N+1.
- Result latency: a `last` command accepted in cycle N gives out_valid=1 in cycle N+1, with out_data and out_ovf equal to the post-op values.
- out_data and out_ovf are held stable while out_valid && !out_ready.
- Throughput: 1 command/cycle and 1 pop/cycle sustained when the FIFO is not full.
- After a pop from a full FIFO, cmd_ready rises in the following cycle.

## Structure
- Shared package `acc_register_pkg`: opcode constants OP_NOP..OP_SHR, opcode width (3), and the `clog2` helper.
- Sub-module `reg_fifo` (WIDTH+1 bits × DEPTH, synchronous push/pop, async reset, full/empty flags).
- The top level holds the accumulator, the ALU/shift mux and the handshake glue.

## Test plan
- Reset, then LOAD 0x1234 with last=1, out_ready=1 → out_valid in the next cycle with out_data=0x1234, out_ovf=0; acc_q=0x1234.
- LOAD 0xFFFF, then ADD 0x0001 last → out_data=0x0000, out_ovf=1. Next, CLR last → out_data=0x0000, out_ovf=0.
- LOAD 0x8001; SHL last → 0x0002 with ovf=1. Then LOAD 0x8001; SHR last → 0x4000 with ovf=0.
- out_ready=0, DEPTH=2, three consecutive `last` LOADs (0x0001, 0x0002, 0x0003) → cmd_ready drops after the second. Raise out_ready → outputs 0x0001 then 0x0002, then the third command is accepted and 0x0003 follows.
- Set clk_ena=0 for 3 cycles with cmd_valid=1 and one FIFO entry pending → cmd_ready=0, out_valid=0, acc_q and the FIFO unchanged. Restore clk_ena → the pending entry is presented.
- With acc_q=0x00AB and one FIFO entry, pulse sclr_n mid-cycle → out_valid and acc_q drop to 0 immediately with no clock edge. After release, no stale entry appears.
